word_to_byte_serializer: RTL and testbench

WORD_TO_BYTE_SERIALIZER -- requirements
Module: word_to_byte_serializer

---
 rtl/word_to_byte_serializer_pkg.sv | 16 +
 rtl/word_to_byte_serializer_if.sv | 27 ++
 rtl/word_to_byte_serializer_byte_sel4.sv | 22 ++
 rtl/word_to_byte_serializer.sv | 85 ++++++++
 tb/tb_word_to_byte_serializer.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/word_to_byte_serializer_pkg.sv
// Shared PHY constants for the word-to-byte serializer:
// idle symbol, bytes per word and FSM state encodings.
package word_to_byte_serializer_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W = 8 * BYTES_PER_WORD;
  localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);
  localparam logic [7:0] IDLE_SYM_DEF = 8'hBC;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/word_to_byte_serializer_if.sv
// Handshake bundle: 32-bit word in (valid/ready), 8-bit byte out.
// master = upstream/downstream side, slave = serializer side.
interface word_to_byte_serializer_if;
  import word_to_byte_serializer_pkg::*;

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        out_data;
  logic              out_valid;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid
  );
endinterface

// File: rtl/word_to_byte_serializer_byte_sel4.sv
// byte_sel4: combinational 32->8 mux, byte k = i_word[8k+7:8k].
// Ports: i_word (32), i_idx (2), o_byte (8).
module byte_sel4
  import word_to_byte_serializer_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [7:0]        o_byte
);

  always_comb begin
    o_byte = i_word[7:0];
    unique case (i_idx)
      2'd0: o_byte = i_word[7:0];
      2'd1: o_byte = i_word[15:8];
      2'd2: o_byte = i_word[23:16];
      2'd3: o_byte = i_word[31:24];
      default: o_byte = i_word[7:0];
    endcase
  end

endmodule

// File: rtl/word_to_byte_serializer.sv
// Serializes 32-bit words into bytes, byte0 first, one byte/cycle.
// Ports: clk, reset (sync, active-low), bus (slave modport).
module word_to_byte_serializer
  import word_to_byte_serializer_pkg::*;
#(
  parameter logic [7:0] IDLE_SYM = IDLE_SYM_DEF
) (
  input  logic clk,
  input  logic reset,
  word_to_byte_serializer_if.slave bus
);

  ser_state_t        r_state;
  logic [WORD_W-1:0] r_cur;
  logic [WORD_W-1:0] r_pend;
  logic              r_pend_valid;
  logic [IDX_W-1:0]  r_cnt;
  logic [7:0]        r_out_data;
  logic              r_out_valid;

  logic       w_ready;
  logic       w_accept;
  logic [7:0] w_byte;

  // Ready depends on registered state only, never on in_valid.
  assign w_ready  = ~r_pend_valid;
  assign w_accept = bus.in_valid & w_ready;

  assign bus.in_ready  = w_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;

  byte_sel4 u_sel (
    .i_word (r_cur),
    .i_idx  (r_cnt),
    .o_byte (w_byte)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_cur        <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_out_data   <= IDLE_SYM;
      r_out_valid  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_out_data  <= IDLE_SYM;
          r_out_valid <= 1'b0;
          if (w_accept) begin
            r_cur   <= bus.in_data;
            r_cnt   <= '0;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          r_out_data  <= w_byte;
          r_out_valid <= 1'b1;
          r_cnt       <= r_cnt + 2'd1;
          if (r_cnt == LAST_IDX) begin
            // Last byte out: reload from pend, else bypass, else idle.
            if (r_pend_valid) begin
              r_cur        <= r_pend;
              r_pend_valid <= 1'b0;
            end else if (w_accept) begin
              r_cur <= bus.in_data;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_accept) begin
            r_pend       <= bus.in_data;
            r_pend_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_to_byte_serializer.sv
// Bench for word_to_byte_serializer: directed + random steps checked
// against a byte-queue reference model.
module tb_word_to_byte_serializer;
  import word_to_byte_serializer_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic acc;

  byte unsigned q[$];

  word_to_byte_serializer_if bus ();

  word_to_byte_serializer #(
    .IDLE_SYM (8'hBC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk8(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: drive, check ready, clock, update model, check outputs.
  task automatic step(input logic v, input logic [31:0] d,
                      input logic rst_n);
    logic [7:0] e_data;
    logic       e_valid;
    @(negedge clk);
    reset = rst_n;
    bus.in_valid = v;
    bus.in_data = d;
    #1;
    // Pending word exists exactly when more than one word of bytes
    // is still owed downstream.
    chk1("in_ready", bus.in_ready, q.size() <= BYTES_PER_WORD);
    acc = v && bus.in_ready && rst_n;
    @(posedge clk);
    e_data = 8'hBC;
    e_valid = 1'b0;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (q.size() > 0) begin
        e_data = q.pop_front();
        e_valid = 1'b1;
      end
      if (acc) begin
        for (int k = 0; k < BYTES_PER_WORD; k++)
          q.push_back(d[8*k +: 8]);
      end
    end
    #1;
    chk1("out_valid", bus.out_valid, e_valid);
    chk8("out_data", bus.out_data, e_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1);
  endtask

  task automatic stream(input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2);
    logic [31:0] ws[$];
    int budget;
    ws = '{w0, w1, w2};
    budget = 40;
    while (ws.size() > 0 && budget > 0) begin
      step(1'b1, ws[0], 1'b1);
      if (acc) void'(ws.pop_front());
      budget--;
    end
    checks++;
    assert (ws.size() == 0) else begin
      errors++;
      $error("FAIL stream_timeout observed=%0d expected=0", ws.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    acc = 1'b0;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;

    // Reset held 3 cycles, then quiet idle.
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    idle(3);

    // Single word.
    step(1'b1, 32'hDDCCBBAA, 1'b1);
    idle(6);

    // Back-to-back words, valid held high through pend-full.
    stream(32'h03020100, 32'h07060504, 32'h0B0A0908);
    idle(14);

    // Reset after byte1 with a word pending.
    step(1'b1, 32'h44332211, 1'b1);
    step(1'b1, 32'h88776655, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    chk1("rst_ready", bus.in_ready, 1'b1);
    idle(8);

    // Bypass: next word accepted while the last byte is going out.
    step(1'b1, 32'h5A5B5C5D, 1'b1);
    idle(3);
    step(1'b1, 32'hE1E2E3E4, 1'b1);
    idle(6);

    // Reset in the same cycle as an offered word drops it.
    step(1'b1, 32'hCAFEF00D, 1'b0);
    idle(3);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom,
           $urandom_range(0, 79) != 0);
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
